// File: rtl/we_scoreboard_decoder_pkg.sv
// Shared defaults for the write-enable scoreboard: register address width,
// outstanding-write limit and the address-0 protection switch.
package we_scoreboard_decoder_pkg;

    localparam int SB_AW           = 5;
    localparam int SB_MAX_PEND     = 4;
    localparam int SB_ZERO_PROTECT = 1;

    // Width needed to count 0..max_pend outstanding writes.
    function automatic int cnt_width(input int max_pend);
        return $clog2(max_pend + 1);
    endfunction

endpackage

// File: rtl/we_scoreboard_decoder_onehot_dec.sv
// Combinational address to one-hot decoder with an enable; the output is
// all-zero when the enable is low.
module onehot_dec #(
    parameter int AW   = 5,
    parameter int NREG = 2**AW
) (
    input  logic [AW-1:0]   addr,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/we_scoreboard_decoder.sv
// Register write scoreboard: tracks registers with an issued but uncommitted
// write and turns each valid commit into a one-cycle one-hot write enable.
module we_scoreboard_decoder
    import we_scoreboard_decoder_pkg::*;
#(
    parameter int AW           = SB_AW,
    parameter int NREG         = 2**AW,
    parameter int MAX_PEND     = SB_MAX_PEND,
    parameter int ZERO_PROTECT = SB_ZERO_PROTECT,
    localparam int CW          = cnt_width(MAX_PEND)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [AW-1:0]   req_addr,
    output logic            req_ready,
    input  logic            commit_valid,
    input  logic [AW-1:0]   commit_addr,
    output logic [NREG-1:0] WEd,
    output logic [NREG-1:0] busy,
    output logic [CW-1:0]   pend_cnt,
    output logic            err
);

    localparam logic [CW-1:0] MAX_PEND_C = CW'(MAX_PEND);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] r_wed;
    logic [CW-1:0]   r_pend_cnt;
    logic            r_err;

    logic            w_req_zero;
    logic            w_cmt_zero;
    logic            w_req_ready;
    logic            w_issue;
    logic            w_commit_hit;
    logic            w_commit_miss;
    logic [NREG-1:0] w_set_oh;
    logic [NREG-1:0] w_wr_oh;

    // Issue handshake: a request transfers on a rising edge where req_valid
    // and req_ready are both high. req_ready looks only at state before the
    // edge, so a same-cycle commit never frees a slot or address early.
    assign w_req_zero  = (ZERO_PROTECT != 0) && (req_addr == '0);
    assign w_cmt_zero  = (ZERO_PROTECT != 0) && (commit_addr == '0);
    assign w_req_ready = w_req_zero | (~r_busy[req_addr] & (r_pend_cnt < MAX_PEND_C));
    assign w_issue     = req_valid & w_req_ready & ~w_req_zero;

    assign w_commit_hit  = commit_valid & ~w_cmt_zero &  r_busy[commit_addr];
    assign w_commit_miss = commit_valid & ~w_cmt_zero & ~r_busy[commit_addr];

    onehot_dec #(.AW(AW), .NREG(NREG)) u_set_dec (
        .addr   (req_addr),
        .en     (w_issue),
        .onehot (w_set_oh)
    );

    // The commit decode serves both as the busy-clear mask and the next WEd.
    onehot_dec #(.AW(AW), .NREG(NREG)) u_wr_dec (
        .addr   (commit_addr),
        .en     (w_commit_hit),
        .onehot (w_wr_oh)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= '0;
            r_wed      <= '0;
            r_pend_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_busy     <= (r_busy | w_set_oh) & ~w_wr_oh;
            r_wed      <= w_wr_oh;
            r_pend_cnt <= r_pend_cnt + CW'(w_issue) - CW'(w_commit_hit);
            if (w_commit_miss) begin
                r_err <= 1'b1;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign WEd       = r_wed;
    assign busy      = r_busy;
    assign pend_cnt  = r_pend_cnt;
    assign err       = r_err;

endmodule

// File: tb/tb_we_scoreboard_decoder.sv
// Bench for we_scoreboard_decoder: directed scenarios with literal
// expectations, then random traffic checked every cycle against a set model.
module tb_we_scoreboard_decoder;

    localparam int AW   = 5;
    localparam int NREG = 32;
    localparam int MAXP = 4;
    localparam int CW   = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic            req_ready;
    logic            commit_valid = 1'b0;
    logic [AW-1:0]   commit_addr = '0;
    logic [NREG-1:0] WEd;
    logic [NREG-1:0] busy;
    logic [CW-1:0]   pend_cnt;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;

    we_scoreboard_decoder #(
        .AW(AW), .NREG(NREG), .MAX_PEND(MAXP), .ZERO_PROTECT(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr),
        .WEd          (WEd),
        .busy         (busy),
        .pend_cnt     (pend_cnt),
        .err          (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit              m_pend[NREG];
    bit              m_err = 1'b0;
    bit              m_live = 1'b0;
    logic [NREG-1:0] exp_q[$];

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    function automatic logic [NREG-1:0] m_busy_vec();
        logic [NREG-1:0] v = '0;
        for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic bit m_ready(input int a);
        if (a == 0) return 1'b1;
        return !m_pend[a] && (m_count() < MAXP);
    endfunction

    always @(posedge clk) begin
        logic [NREG-1:0] wed;
        bit              rdy;
        wed = '0;
        if (reset) begin
            for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
            m_err  = 1'b0;
            m_live = 1'b1;
        end else begin
            rdy = m_ready(int'(req_addr));
            if (commit_valid && commit_addr != 0) begin
                if (m_pend[commit_addr]) begin
                    m_pend[commit_addr] = 1'b0;
                    wed = NREG'(1) << commit_addr;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (req_valid && rdy && req_addr != 0) m_pend[req_addr] = 1'b1;
        end
        if (m_live) exp_q.push_back(wed);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            logic [NREG-1:0] e;
            check("model_busy", 64'(busy), 64'(m_busy_vec()));
            check("model_pend_cnt", 64'(pend_cnt), 64'(m_count()));
            check("model_err", 64'(err), 64'(m_err));
            check("model_req_ready", 64'(req_ready), 64'(m_ready(int'(req_addr))));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("model_WEd", 64'(WEd), 64'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        commit_valid = 1'b0;
        req_addr = '0;
        commit_addr = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic issue(input int a);
        req_valid = 1'b1;
        req_addr = AW'(a);
        step();
        req_valid = 1'b0;
    endtask

    task automatic commit(input int a);
        commit_valid = 1'b1;
        commit_addr = AW'(a);
        step();
        commit_valid = 1'b0;
    endtask

    initial begin
        reset_dut();
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_wed", 64'(WEd), 64'h0);
        check("reset_pend", 64'(pend_cnt), 64'h0);
        check("reset_err", 64'(err), 64'h0);

        // Single issue/commit round trip on register 5.
        req_valid = 1'b1; req_addr = 5'd5; #1;
        check("r5_ready", 64'(req_ready), 64'h1);
        step(); req_valid = 1'b0;
        check("r5_busy_c1", 64'(busy), 64'h20);
        check("r5_pend_c1", 64'(pend_cnt), 64'h1);
        check("r5_wed_c1", 64'(WEd), 64'h0);
        step();
        check("r5_busy_c2", 64'(busy), 64'h20);
        commit(5);
        check("r5_wed", 64'(WEd), 64'h0000_0020);
        check("r5_busy_done", 64'(busy), 64'h0);
        check("r5_pend_done", 64'(pend_cnt), 64'h0);
        step();
        check("r5_wed_once", 64'(WEd), 64'h0);

        // Fill to the limit, then a commit in the same cycle must not open ready.
        for (int a = 1; a <= 4; a++) issue(a);
        req_valid = 1'b1; req_addr = 5'd6; #1;
        check("full_ready", 64'(req_ready), 64'h0);
        check("full_pend", 64'(pend_cnt), 64'h4);
        step();
        check("full_pend_sat", 64'(pend_cnt), 64'h4);
        check("full_no6", 64'(busy[6]), 64'h0);
        commit_valid = 1'b1; commit_addr = 5'd1; #1;
        check("full_ready_commit", 64'(req_ready), 64'h0);
        step(); commit_valid = 1'b0; #1;
        check("full_ready_after", 64'(req_ready), 64'h1);
        step(); req_valid = 1'b0;
        check("full_busy6", 64'(busy), 64'h5C);
        check("full_pend6", 64'(pend_cnt), 64'h4);

        // Commit to an idle register is a sticky error.
        reset_dut();
        commit(9);
        check("err_set", 64'(err), 64'h1);
        check("err_wed", 64'(WEd), 64'h0);
        step();
        check("err_sticky", 64'(err), 64'h1);
        reset_dut();
        check("err_cleared", 64'(err), 64'h0);

        // Simultaneous issue 7 and commit 3.
        issue(3);
        req_valid = 1'b1; req_addr = 5'd7;
        commit(3); req_valid = 1'b0;
        check("swap_busy", 64'(busy), 64'h80);
        check("swap_wed", 64'(WEd), 64'h0000_0008);
        check("swap_pend", 64'(pend_cnt), 64'h1);

        // Address 0 is neither tracked nor written.
        reset_dut();
        req_valid = 1'b1; req_addr = '0; commit_valid = 1'b1; commit_addr = '0; #1;
        check("zero_ready", 64'(req_ready), 64'h1);
        step(); idle_inputs();
        check("zero_busy", 64'(busy), 64'h0);
        check("zero_wed", 64'(WEd), 64'h0);
        check("zero_err", 64'(err), 64'h0);

        // Issue to the register being committed is refused, then retried.
        issue(10);
        req_valid = 1'b1; req_addr = 5'd10; commit_valid = 1'b1; commit_addr = 5'd10; #1;
        check("same_ready", 64'(req_ready), 64'h0);
        step(); commit_valid = 1'b0;
        check("same_wed", 64'(WEd), 64'h400);
        check("same_busy", 64'(busy), 64'h0);
        #1;
        check("same_retry_ready", 64'(req_ready), 64'h1);
        step(); req_valid = 1'b0;
        check("same_retry_busy", 64'(busy), 64'h400);

        // Reset overrides a commit with three writes pending.
        reset_dut();
        issue(1); issue(2); issue(3);
        commit_valid = 1'b1; commit_addr = 5'd1; reset = 1'b1;
        step();
        reset = 1'b0; commit_valid = 1'b0;
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_pend", 64'(pend_cnt), 64'h0);
        check("rst_wed", 64'(WEd), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_no_wed", 64'(WEd), 64'h0);
        end

        // Random traffic, mostly on a small address window to force collisions.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int pq[$];
            reset = ($urandom_range(0, 249) == 0);
            req_valid = $urandom_range(0, 1) != 0;
            req_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 31))
                                                    : AW'($urandom_range(0, 12));
            commit_valid = $urandom_range(0, 2) != 0;
            for (int i = 0; i < NREG; i++) if (m_pend[i]) pq.push_back(i);
            if (pq.size() > 0 && $urandom_range(0, 9) < 8)
                commit_addr = AW'(pq[$urandom_range(0, pq.size() - 1)]);
            else
                commit_addr = AW'($urandom_range(0, 12));
            step();
        end
        reset = 1'b0;
        idle_inputs();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
